// File: rtl/phys_regfile.sv
// phys_regfile: physical register file with ready scoreboard, CDB write-through bypass and ready population count
module phys_regfile #(
  parameter int XLEN = 32,
  parameter int NUM_PREGS = 64,
  parameter int IDX_W = $clog2(NUM_PREGS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IDX_W-1:0] rs1_preg_idx,
  input  logic [IDX_W-1:0] rs2_preg_idx,
  output logic [XLEN-1:0]  rs1_preg_data,
  output logic [XLEN-1:0]  rs2_preg_data,
  output logic             rs1_ready,
  output logic             rs2_ready,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [XLEN-1:0]  wr_data,
  input  logic             alloc_en,
  input  logic [IDX_W-1:0] alloc_idx,
  output logic [IDX_W:0]   ready_count
);
  logic [XLEN-1:0]      data [NUM_PREGS];
  logic [NUM_PREGS-1:0] rdy;
  logic [NUM_PREGS-1:0] rdy_nxt;
  logic [IDX_W:0]       cnt_nxt;
  logic                 byp1;
  logic                 byp2;
  assign byp1 = wr_en && wr_idx == rs1_preg_idx;
  assign byp2 = wr_en && wr_idx == rs2_preg_idx;
  assign rs1_preg_data = rs1_preg_idx == '0 ? '0 : byp1 ? wr_data : data[rs1_preg_idx];
  assign rs2_preg_data = rs2_preg_idx == '0 ? '0 : byp2 ? wr_data : data[rs2_preg_idx];
  assign rs1_ready = rs1_preg_idx == '0 || byp1 || rdy[rs1_preg_idx];
  assign rs2_ready = rs2_preg_idx == '0 || byp2 || rdy[rs2_preg_idx];
  // next ready vector: writeback sets, allocation clears afterwards so the newer instruction wins
  always_comb begin
    rdy_nxt = rdy;
    if (wr_en && wr_idx != '0) rdy_nxt[wr_idx] = 1'b1;
    if (alloc_en && alloc_idx != '0) rdy_nxt[alloc_idx] = 1'b0;
    rdy_nxt[0] = 1'b1;
  end
  // population count of the post-edge ready vector
  always_comb begin
    cnt_nxt = '0;
    for (int i = 0; i < NUM_PREGS; i++) cnt_nxt = cnt_nxt + (IDX_W+1)'(rdy_nxt[i]);
  end
  // scoreboard and count state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdy <= '1;
      ready_count <= (IDX_W+1)'(NUM_PREGS);
    end else begin
      rdy <= rdy_nxt;
      ready_count <= cnt_nxt;
    end
  end
  // data array; preg 0 is never written so it stays zero
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_PREGS; i++) data[i] <= '0;
    end else if (wr_en && wr_idx != '0) begin
      data[wr_idx] <= wr_data;
    end
  end
endmodule

// File: doc/phys_regfile.md
# phys_regfile

Physical register file with per-register ready scoreboard, serving the two source-operand reads issued by the issue stage. It returns operand values and readiness combinationally, with same-cycle write-through bypass from the completion (CDB) write port. It also accepts destination allocations from rename/dispatch, which clear readiness until the producing instruction writes back. It sits between the issue stage (read initiator), the complete stage (writer) and dispatch (allocator).

## Interface
- XLEN, 32, data width
- NUM_PREGS, 64, number of physical registers; must be a power of two, at least 2
- IDX_W, $clog2(NUM_PREGS), physical register index width
- clock  in  1  single clock; all state updates on posedge
- reset  in  1  asynchronous, active-high; clears all state immediately
- rs1_preg_idx  in  IDX_W  read port 1 index (from issue)
- rs2_preg_idx  in  IDX_W  read port 2 index (from issue)
- rs1_preg_data  out  XLEN  read port 1 value
- rs2_preg_data  out  XLEN  read port 2 value
- rs1_ready  out  1  read port 1 value is valid (produced)
- rs2_ready  out  1  read port 2 value is valid (produced)
- wr_en  in  1  completion write strobe
- wr_idx  in  IDX_W  completion destination preg
- wr_data  in  XLEN  completion result
- alloc_en  in  1  dispatch allocated a new destination preg
- alloc_idx  in  IDX_W  allocated preg; its ready bit clears
- ready_count  out  IDX_W+1  number of pregs with ready=1, registered

## Operation
- Storage: data[NUM_PREGS] of XLEN, ready[NUM_PREGS] of 1 bit.
- Preg 0 is the hardwired zero register: it always reads 0 with ready=1. Writes to it are ignored, and allocations of it are ignored.
- Write: on posedge with wr_en and wr_idx!=0, data[wr_idx]<=wr_data and ready[wr_idx]<=1.
- Alloc: on posedge with alloc_en and alloc_idx!=0, ready[alloc_idx]<=0. Data is untouched.
- Same-cycle write and alloc to the same nonzero idx: data is written and ready ends at 0. Alloc wins, since the alloc belongs to a newer instruction.
- Same-cycle write and alloc to different idx: both take effect.
- Read, per port p (combinational):
  - If idx==0: data=0, ready=1.
  - Else if wr_en and wr_idx==idx: data=wr_data, ready=1. This is write-through bypass.
  - Else: data=data[idx], ready=ready[idx].
- Bypass ignores alloc_en, so a same-cycle alloc of the read idx does not affect that cycle's read output.
- Both ports are independent and may read the same idx.
- ready_count: registered population count of the ready array after the clock edge's updates. This equals the previous count + (write sets a 0→1 bit) − (alloc clears a 1→0 bit). Preg 0 is always counted. The count never exceeds NUM_PREGS.
- Any index is in range by construction, so there is no out-of-range handling.

## Timing
- Reset (asynchronous, takes effect without clock):
  - all data=0, all ready=1
  - ready_count=NUM_PREGS
  - read outputs become 0 / ready=1 combinationally, unless bypass is active
- Read latency: 0 cycles (combinational from idx and write port).
- Write visibility: in the same cycle via bypass, and from array storage the next cycle.
- Alloc visibility: ready drops from the cycle after the alloc edge.
- ready_count reflects the state after each edge, with 1-cycle latency from inputs.
- Reset mid-operation discards pending write/alloc at that edge. The first post-reset edge behaves normally.

## Test plan
- Reset: assert reset mid-cycle with no clock edge. Then all pregs read 0 with ready=1, and ready_count=64.
- Alloc/write: alloc preg 5, then rs1_preg_idx=5 gives ready=0. Write 5=0xDEADBEEF, then in the same cycle rs1_data=0xDEADBEEF with ready=1 (bypass). On the next cycle the same values come from the array. ready_count goes 64→63→64.
- Zero register: wr_en with idx 0 and data 0x1234, plus alloc_en with idx 0. Both ports at idx 0 read 0 with ready=1, and ready_count is unchanged.
- Collision: alloc 7 and write 7=0x55 in the same edge. Afterwards data[7]=0x55, ready[7]=0, ready_count decremented by 1.
- Dual read: rs1=rs2=9 while writing 9=0xA. Both ports show 0xA with ready=1. Meanwhile a different index, 10 (allocated earlier), shows ready=0.
- Random: constrained-random alloc/write/read sequences against a reference model. Check data, ready and ready_count every cycle, including async reset pulses injected between edges.
